// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, funct3 width codes and lane count for the data-memory responder.
package dmem_pkg;
  localparam int LANES = 4;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic logic f3_legal(input logic [2:0] f);
    return f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-enable/store-data alignment and load extraction/extension from addr[1:0] and funct3.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]       addr,
  input  logic [2:0]       funct3,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rword,
  output logic [LANES-1:0] be,
  output logic [31:0]      wdata_al,
  output logic [31:0]      rdata
);
  logic       byte_sz, half_sz, uns;
  logic [1:0] off;
  logic [31:0] sh;
  // Any width code that is neither byte nor half behaves as a word access.
  always_comb begin
    byte_sz  = funct3[1:0] == 2'b00;
    half_sz  = funct3[1:0] == 2'b01;
    uns      = funct3[2];
    off      = byte_sz ? addr : half_sz ? {addr[1], 1'b0} : 2'b00;
    be       = byte_sz ? 4'b0001 << off : half_sz ? 4'b0011 << off : 4'b1111;
    wdata_al = wdata << {off, 3'b000};
    sh       = rword >> {off, 3'b000};
    rdata    = byte_sz ? {{24{~uns & sh[7]}}, sh[7:0]} :
               half_sz ? {{16{~uns & sh[15]}}, sh[15:0]} : rword;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready data-memory responder with programmable latency.
// Define DMEM_ERR_EN to flag misaligned, out-of-range and illegal-width accesses via rsp_err.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  state_t state, nxt;
  logic [3:0]            cnt;
  logic                  we_q, err_q, err_in, accept, exec;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, wd, ld, rword;
  logic [2:0]            f3_q;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] mem [WORDS];

`ifdef DMEM_ERR_EN
  always_comb
    err_in = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
             (req_funct3 == F3_W && req_addr[1:0] != 2'b00) ||
             (|req_addr[31:ADDR_WIDTH]) || !f3_legal(req_funct3) ||
             (req_funct3[2] && req_we);
`else
  logic unused;
  assign err_in = 1'b0;
  assign unused = ^req_addr[31:ADDR_WIDTH];
`endif

  assign accept = state == IDLE && req_valid;
  assign exec   = state == BUSY && cnt == 4'd0;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? BUSY : IDLE;
      BUSY:    nxt = cnt == 4'd0 ? RESP : BUSY;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        err_q   <= err_in;
        addr_q  <= req_addr[ADDR_WIDTH-1:0];
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (exec) begin
        rsp_rdata <= (we_q || err_q) ? '0 : ld;
        rsp_err   <= err_q;
      end
    end

  // Storage is deliberately outside reset; an abandoned BUSY never reaches exec.
  always_ff @(posedge clk)
    if (exec && we_q && !err_q)
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wd[8*i +: 8];

  assign rword = mem[addr_q[ADDR_WIDTH-1:2]];

  dmem_lane_align u_align (
    .addr    (addr_q[1:0]),
    .funct3  (f3_q),
    .wdata   (wdata_q),
    .rword   (rword),
    .be      (be),
    .wdata_al(wd),
    .rdata   (ld)
  );
endmodule
